booth_divider: RTL and testbench
================================

// Module: booth_divider
// PURPOSE
//  Sequential signed divider; inverse of the 9-bit Booth multiplier block.
//  Takes a 2W-bit signed dividend (a Product-width word) and a W-bit signed divisor.
//  Returns a W-bit quotient and a W-bit remainder using restoring division on magnitudes.
//  Sits beside the multiplier in the arithmetic datapath, so multiply/divide round trips are checkable.
// PARAMETERS
//  W    9    operand width; dividend is 2W bits, divisor/quotient/remainder are W bits
// PORTS
//  Clk        in   1     single clock; all state changes on rising edge
//  Reset_n    in   1     asynchronous, active-low reset
//  Start      in   1     request; sampled only in IDLE
//  Data_A     in   2W    signed dividend (two's complement)
//  Data_B     in   W     signed divisor (two's complement)
//  Busy       out  1     high from the edge accepting Start until the edge raising Done
//  Done       out  1     one-cycle pulse: results valid
//  Quotient   out  W     signed quotient, truncated toward zero
//  Remainder  out  W     signed remainder; sign follows dividend, |R| < |divisor|
//  Overflow   out  1     quotient not representable in W signed bits
//  Div_Zero   out  1     divisor was zero
// BEHAVIOUR
//  Reset (async, Reset_n=0): state=IDLE; Busy, Done, Quotient, Remainder, Overflow, Div_Zero all 0.
//  Reset mid-operation: the division is abandoned. No Done is issued. Outputs clear immediately.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  IDLE:
//   - On an edge with Start=1, latch Data_A and Data_B.
//   - Latch sign flags; form unsigned magnitudes (|A| 2W bits, |B| W bits).
//   - Clear partial remainder; Busy=1.
//   - Next state is CALC, or FIX if B==0.
//  CALC: exactly 2W iterations (counter 0..2W-1). Each edge:
//   - Shift {rem, quo} left by 1.
//   - Trial subtract |B| from rem (W+1 bits).
//   - If the result is non-negative: keep it and set quo LSB=1. Otherwise restore rem and set quo LSB=0.
//  FIX (one edge): apply signs.
//   - q = neg(A) xor neg(B) ? -quo : quo.
//   - r = neg(A) ? -rem : rem.
//   - Overflow when quo > 2^(W-1)-1 for a positive q, or quo > 2^(W-1) for a negative q.
//   - On overflow, Quotient saturates to +(2^(W-1)-1) or -2^(W-1) by sign, and Remainder=0.
//   - On divide-by-zero: Quotient=0, Remainder=0, Div_Zero=1, Overflow=0.
//   - Outputs register on this edge.
//  DONE (one edge): Done=1 for exactly one cycle; Busy=0 on the same edge.
//  Latency, Start edge to Done-high edge:
//   - normal: 2W+2 edges (20 for W=9);
//   - divide-by-zero: 2 edges.
//  Start while Busy=1 or in DONE is ignored; operands are not re-sampled.
//  Back-to-back: Start may be asserted in the cycle Done is high. It is accepted on the following IDLE edge.
//  Quotient, Remainder, Overflow and Div_Zero hold their values until the next FIX edge.
//  They do not change while inputs change mid-operation.
//  Edge case: dividend -2^(2W-1) uses magnitude 2^(2W-1), which fits 2W unsigned bits. No special handling.
//  Divisor -2^(W-1): magnitude 2^(W-1), which fits W unsigned bits.
// TESTING
//  T1: A=100, B=7 -> Q=14, R=2, Overflow=0, Done exactly 20 edges after Start.
//  T2: A=-100, B=7 -> Q=-14, R=-2. A=100, B=-7 -> Q=-14, R=2. A=-100, B=-7 -> Q=14, R=-2.
//  T3: A=4096, B=2 -> Overflow=1, Q=255, R=0. A=-2048, B=8 -> Q=-256, R=0, Overflow=0.
//  T4: A=1234, B=0 -> Div_Zero=1, Q=0, R=0, Done 2 edges after Start. Next normal op is unaffected.
//  T5: pulse Reset_n low at CALC iteration 10 -> outputs 0 immediately, no Done.
//      Start 5 cycles later gives a correct result.
//  T6: second Start during Busy (A=50, B=5) is ignored; result is the first op.
//      Random sweep: Booth Product of (a,b) divided by b returns Q=a, R=0 for b != 0.

Source files
------------

// File: rtl/booth_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : booth_divider_if
//  Purpose  : Request/result bundle for the sequential signed divider.
//             The master drives a request and reads back status and results.
//             The slave (the divider) samples the request and drives results.
//  Revision : 1.0  initial release
// ============================================================================
interface booth_divider_if #(
    parameter int W = 9
);
    logic             Start;
    logic [2*W-1:0]   Data_A;
    logic [W-1:0]     Data_B;
    logic             Busy;
    logic             Done;
    logic [W-1:0]     Quotient;
    logic [W-1:0]     Remainder;
    logic             Overflow;
    logic             Div_Zero;

    modport master (
        output Start, Data_A, Data_B,
        input  Busy, Done, Quotient, Remainder, Overflow, Div_Zero
    );

    modport slave (
        input  Start, Data_A, Data_B,
        output Busy, Done, Quotient, Remainder, Overflow, Div_Zero
    );
endinterface
`default_nettype wire

// File: rtl/booth_divider.sv
`default_nettype none
// ============================================================================
//  Module   : booth_divider
//  Purpose  : Sequential signed divider, 2W-bit dividend by W-bit divisor.
//             Restoring division on magnitudes (one quotient bit per clock),
//             then a sign-fix step with saturation and divide-by-zero flags.
//  Revision : 1.0  initial release
// ============================================================================
module booth_divider #(
    parameter int W = 9
) (
    input  wire logic        Clk,
    input  wire logic        Reset_n,
    booth_divider_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int              CW          = $clog2(2*W);
    localparam logic [CW-1:0]   c_LAST_ITER = CW'(2*W-1);
    // Largest magnitudes a W-bit signed quotient can carry, per sign.
    localparam logic [2*W-1:0]  c_QPOS_LIM  = (2*W)'((1 << (W-1)) - 1);
    localparam logic [2*W-1:0]  c_QNEG_LIM  = (2*W)'(1 << (W-1));
    localparam logic [W-1:0]    c_SAT_POS   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]    c_SAT_NEG   = {1'b1, {(W-1){1'b0}}};

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_sa;
    logic             r_sb;
    logic             r_dz;
    logic [2*W-1:0]   r_quo;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_bmag;
    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_q;
    logic [W-1:0]     r_r;
    logic             r_ovf;
    logic             r_divz;

    logic [2*W-1:0]   w_amag;
    logic [W-1:0]     w_bmag;
    logic [W:0]       w_rem_sh;
    logic [W:0]       w_trial;
    logic             w_qneg;
    logic             w_ovf;
    logic [W-1:0]     w_q_signed;
    logic [W-1:0]     w_r_signed;

    // Operand magnitudes; the most negative values map onto their unsigned
    // magnitude, which still fits the same width.
    assign w_amag = bus.Data_A[2*W-1] ? (~bus.Data_A + 1'b1) : bus.Data_A;
    assign w_bmag = bus.Data_B[W-1]   ? (~bus.Data_B + 1'b1) : bus.Data_B;

    // One restoring step: the partial remainder is always below |B|, so after
    // the shift it is below 2|B| and a W+1 bit difference keeps a valid sign.
    assign w_rem_sh = {r_rem, r_quo[2*W-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_bmag};

    // Sign application and range check of the unsigned quotient.
    assign w_qneg     = r_sa ^ r_sb;
    assign w_ovf      = w_qneg ? (r_quo > c_QNEG_LIM) : (r_quo > c_QPOS_LIM);
    assign w_q_signed = w_qneg ? (~r_quo[W-1:0] + 1'b1) : r_quo[W-1:0];
    assign w_r_signed = r_sa   ? (~r_rem + 1'b1)        : r_rem;

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz    <= 1'b0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_bmag  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_ovf   <= 1'b0;
            r_divz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.Start) begin
                        r_sa    <= bus.Data_A[2*W-1];
                        r_sb    <= bus.Data_B[W-1];
                        r_quo   <= w_amag;
                        r_bmag  <= w_bmag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_dz    <= (bus.Data_B == '0);
                        r_state <= (bus.Data_B == '0) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    if (!w_trial[W]) begin
                        r_rem <= w_trial[W-1:0];
                        r_quo <= {r_quo[2*W-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[W-1:0];
                        r_quo <= {r_quo[2*W-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_q    <= '0;
                        r_r    <= '0;
                        r_ovf  <= 1'b0;
                        r_divz <= 1'b1;
                    end else if (w_ovf) begin
                        r_q    <= w_qneg ? c_SAT_NEG : c_SAT_POS;
                        r_r    <= '0;
                        r_ovf  <= 1'b1;
                        r_divz <= 1'b0;
                    end else begin
                        r_q    <= w_q_signed;
                        r_r    <= w_r_signed;
                        r_ovf  <= 1'b0;
                        r_divz <= 1'b0;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.Quotient  = r_q;
    assign bus.Remainder = r_r;
    assign bus.Overflow  = r_ovf;
    assign bus.Div_Zero  = r_divz;

endmodule
`default_nettype wire

// File: tb/tb_booth_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_divider
//  Purpose  : Self-checking bench for booth_divider (W=9): directed cases,
//             reset abort, ignored Start while busy, product/divisor sweep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_booth_divider;

    localparam int W = 9;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ov;
        logic         dz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   start_cyc;
    exp_t sb[$];

    booth_divider_if #(.W(W)) bus ();

    booth_divider #(.W(W)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to measure Start-to-Done latency.
    always @(posedge clk) cyc = cyc + 1;

    // Global safety net in case a wait is ever left unbounded.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: SV integer division truncates toward zero and the remainder
    // takes the dividend's sign, matching the required semantics.
    function automatic exp_t model(input longint a, input longint b);
        exp_t   e;
        longint q;
        longint r;
        e = '0;
        if (b == 0) begin
            e.dz = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            if (q > 255) begin
                e.ov = 1'b1; e.q = 9'h0FF;
            end else if (q < -256) begin
                e.ov = 1'b1; e.q = 9'h100;
            end else begin
                e.q = q[W-1:0];
                e.r = r[W-1:0];
            end
        end
        return e;
    endfunction

    // Present an operation; returns just after the accepting edge.
    task automatic launch(input longint a, input longint b, input bit push);
        @(negedge clk);
        bus.Start  = 1'b1;
        bus.Data_A = a[2*W-1:0];
        bus.Data_B = b[W-1:0];
        if (push) sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        start_cyc  = cyc;
        bus.Start  = 1'b0;
        check("busy_after_start", {31'b0, bus.Busy}, 32'd1);
        check("done_low_after_start", {31'b0, bus.Done}, 32'd0);
    endtask

    // Wait (bounded) for Done, check latency and compare against scoreboard.
    task automatic wait_done(input string tag, input int exp_lat);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.Done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'b0, got}, 32'd1);
        if (got) begin
            check({tag, "_latency"}, cyc - start_cyc, exp_lat);
            check({tag, "_busy_low"}, {31'b0, bus.Busy}, 32'd0);
        end
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_Q"},  {23'b0, bus.Quotient},  {23'b0, e.q});
            check({tag, "_R"},  {23'b0, bus.Remainder}, {23'b0, e.r});
            check({tag, "_OV"}, {31'b0, bus.Overflow},  {31'b0, e.ov});
            check({tag, "_DZ"}, {31'b0, bus.Div_Zero},  {31'b0, e.dz});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_Busy"}, {31'b0, bus.Busy},      32'd0);
        check({tag, "_Done"}, {31'b0, bus.Done},      32'd0);
        check({tag, "_Q"},    {23'b0, bus.Quotient},  32'd0);
        check({tag, "_R"},    {23'b0, bus.Remainder}, 32'd0);
        check({tag, "_OV"},   {31'b0, bus.Overflow},  32'd0);
        check({tag, "_DZ"},   {31'b0, bus.Div_Zero},  32'd0);
    endtask

    initial begin
        int     done_cnt;
        longint ra;
        longint rb;
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        start_cyc  = 0;
        rst_n      = 1'b0;
        bus.Start  = 1'b0;
        bus.Data_A = '0;
        bus.Data_B = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // T1
        launch(100, 7, 1'b1);    wait_done("t1", 20);
        // T2: sign combinations
        launch(-100, 7, 1'b1);   wait_done("t2a", 20);
        launch(100, -7, 1'b1);   wait_done("t2b", 20);
        launch(-100, -7, 1'b1);  wait_done("t2c", 20);
        // T3: overflow saturation and the exact negative limit
        launch(4096, 2, 1'b1);   wait_done("t3a", 20);
        launch(-2048, 8, 1'b1);  wait_done("t3b", 20);
        launch(-131072, -256, 1'b1); wait_done("t3c", 20);
        launch(-131072, 255, 1'b1);  wait_done("t3d", 20);
        // T4: divide by zero, then a normal op
        launch(1234, 0, 1'b1);   wait_done("t4", 2);
        launch(100, 7, 1'b1);    wait_done("t4_next", 20);

        // T5: reset in the middle of CALC (iteration 10)
        launch(-1000, 9, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_abort");
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.Done) done_cnt++;
        end
        check("t5_no_done", done_cnt, 0);
        repeat (4) @(negedge clk);
        launch(-3000, 50, 1'b1); wait_done("t5_after", 20);

        // T6: a second Start during Busy is ignored
        launch(1000, -3, 1'b1);
        repeat (3) @(negedge clk);
        bus.Start  = 1'b1;
        bus.Data_A = 18'd50;
        bus.Data_B = 9'd5;
        @(negedge clk);
        bus.Start  = 1'b0;
        wait_done("t6", 20);
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.Done) done_cnt++;
        end
        check("t6_single_done", done_cnt, 0);

        // Sweep: product of two signed W-bit values divided by one of them
        for (int i = 0; i < 12; i++) begin
            ra = longint'($urandom_range(511)) - 256;
            rb = longint'($urandom_range(511)) - 256;
            if (rb == 0) rb = 1;
            launch(ra * rb, rb, 1'b1);
            wait_done("sweep", 20);
            check("sweep_Q_is_a", {23'b0, bus.Quotient}, {23'b0, ra[W-1:0]});
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
